// File: rtl/uart_pkg.sv
// Shared definitions for the UART front end: debounce FSM encoding and
// the default qualification window.
package uart_pkg;

  localparam logic [1:0] DB_ZERO  = 2'd0;
  localparam logic [1:0] DB_WAIT1 = 2'd1;
  localparam logic [1:0] DB_ONE   = 2'd2;
  localparam logic [1:0] DB_WAIT0 = 2'd3;

  // 10 ms at 100 MHz
  localparam int DB_STABLE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    ST_ZERO  = DB_ZERO,
    ST_WAIT1 = DB_WAIT1,
    ST_ONE   = DB_ONE,
    ST_WAIT0 = DB_WAIT0
  } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Debounces a synchronized mechanical input: a new level is accepted only
// after it has held for STABLE_CYCLES consecutive clocks.
module debounce_filter
  import uart_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
  parameter int CW            = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db,
  output logic settling
);

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s2;
  db_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cnt_done;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A bounce back to the old level aborts qualification; the count only
  // restarts from 0 on the next entry into a WAIT state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ZERO: begin
        if (s2) begin
          state_nxt = ST_WAIT1;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT1: begin
        if (!s2)           state_nxt = ST_ZERO;
        else if (cnt_done) state_nxt = ST_ONE;
        else               cnt_nxt   = cnt + CW'(1);
      end
      ST_ONE: begin
        if (!s2) begin
          state_nxt = ST_WAIT0;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT0: begin
        if (s2)            state_nxt = ST_ONE;
        else if (cnt_done) state_nxt = ST_ZERO;
        else               cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = ST_ZERO;
    endcase
  end

  assign db       = (state == ST_ONE)   || (state == ST_WAIT0);
  assign settling = (state == ST_WAIT1) || (state == ST_WAIT0);

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Synchronizes and debounces a raw asynchronous mechanical input (push-button or switch) into a clean single-clock-domain level `db`. It is the stage directly upstream of the positive-edge detector, which consumes `db` to produce one-cycle pulses for the UART control logic. A change on the raw input is accepted only after the synchronized value has held constant for `STABLE_CYCLES` consecutive clocks.

## Interface
- `STABLE_CYCLES`, default 1_000_000, is the number of consecutive stable clocks needed to accept a change (10 ms at 100 MHz). Legal range is ≥ 2.
- `CW`, default `$clog2(STABLE_CYCLES)`, is the counter width. It is derived and must not be overridden.

Ports:
- `clk`, input, 1 bit: system clock. One clock domain for the whole block.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `btn_in`, input, 1 bit: raw asynchronous, bouncing input.
- `db`, output, 1 bit: debounced level, synchronous to `clk`.
- `settling`, output, 1 bit: high while a candidate change is being qualified (the WAIT states).

## Operation
- **Synchronizer.** Two flops, `s1 <= btn_in` and `s2 <= s1`. Only `s2` drives the rest of the logic.
- **FSM states.** ZERO, WAIT1, ONE, WAIT0. The state register is `state`; the `CW`-bit counter is `cnt`.
- **ZERO.** If `s2==1`, go to WAIT1 and set `cnt<=0`. Otherwise stay.
- **WAIT1.**
  - If `s2==0`, go back to ZERO (candidate rejected).
  - Else if `cnt==STABLE_CYCLES-1`, go to ONE.
  - Else `cnt<=cnt+1`.
- **ONE.** If `s2==0`, go to WAIT0 and set `cnt<=0`. Otherwise stay.
- **WAIT0.** This is the mirror of WAIT1.
  - If `s2==1`, go back to ONE.
  - Else if `cnt==STABLE_CYCLES-1`, go to ZERO.
  - Else `cnt<=cnt+1`.
- **Outputs.** Both are Moore decodes of the state, with no extra register.
  - `db = (state==ONE)|(state==WAIT0)`.
  - `settling = (state==WAIT1)|(state==WAIT0)`.
- **Counter.** It never wraps. The terminal compare at `STABLE_CYCLES-1` ends counting, and `cnt` is don't-care in ZERO and ONE.
- **Glitch rejection.** Any bounce back to the old level during a WAIT state aborts qualification. A later change restarts the count from 0.
- **Reset.** On any edge where `reset==1`, the block sets `s1=s2=0`, `state=ZERO`, `cnt=0`. This drives `db=0` and `settling=0`.
  - Reset mid-WAIT or in ONE returns to ZERO unconditionally.
  - If `btn_in` is still held high, a full qualification window is required after reset releases.

## Timing
- Raw edge on `btn_in` meeting setup before clock edge k:
  - `s2` changes after edge k+1.
  - The FSM enters WAIT at edge k+2.
  - `db` changes after edge k+2+STABLE_CYCLES.
- Total latency is STABLE_CYCLES+3 edges, counting edge k.
- `settling` is high for exactly STABLE_CYCLES cycles on an accepted change.
- `db` is glitch-free and changes at most once per qualification window. A minimum of STABLE_CYCLES+1 cycles separates two `db` transitions.
- An `s2` pulse of fewer than STABLE_CYCLES+1 cycles, measured from the WAIT entry, never reaches `db`.
- Reset has priority over all FSM transitions on the same edge.

## Structure
- **Shared package `uart_pkg`.** Holds the state encoding localparams `DB_ZERO=2'd0`, `DB_WAIT1=2'd1`, `DB_ONE=2'd2`, `DB_WAIT0=2'd3`, plus the default debounce constant `DB_STABLE_DEFAULT`.
- **Sub-module `sync_2ff`.** A generic two-flop synchronizer with `clk`, `reset`, `d`, `q` and reset value 0. It is reused by the UART receive path.
- **Top level.** The FSM and counter live in the `debounce_filter` top.

## Test plan
All scenarios use STABLE_CYCLES=4.
1. **Reset values.** Assert `reset` for 2 cycles with `btn_in=1` → `db=0` and `settling=0` during reset. After release, `db` rises exactly 7 edges after the first non-reset edge.
2. **Clean press.** `btn_in` 0→1 before edge 0 and held → `settling=1` after edges 2–5, `db=1` after edge 6. Release before edge 20 → `db=0` after edge 26.
3. **Bounce rejection.** `btn_in` toggles 1,0,1,0 every 2 cycles, then settles at 1 → `db` stays 0 through the bounce. It rises only STABLE_CYCLES+3 edges after the last 0→1 transition.
4. **Short glitch.** In ONE, drive `btn_in` low for 3 cycles → `settling` pulses high and `db` stays 1 throughout.
5. **Reset mid-qualification.** Assert `reset` while in WAIT1 with `cnt=2` → `state=ZERO` and `db=0` on the next edge. With `btn_in` held high, a full 4-cycle window is observed before `db=1`.
6. **Boundary.** STABLE_CYCLES=2 with `btn_in` held high → `db=1` after edge 4, i.e. 5 edges of latency.
